synch_up_counter: RTL and testbench

- Free-running synchronous binary up-counter; WIDTH-bit output Q increments by one on every rising clock edge.
- All flip-flops share the single clock (no ripple clocking).
- Built as a chain of toggle flip-flops with carry-lookahead toggle enables.
- Used as a basic timing/sequence source and as the reference synchronous-counter block in the design.

---
 rtl/synch_up_counter_t_ff.sv | 22 ++
 rtl/synch_up_counter.sv | 29 ++
 tb/tb_synch_up_counter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/synch_up_counter_t_ff.sv
// Single toggle flip-flop with asynchronous active-low clear.
// One instance per counter bit.
module t_ff (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ t;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= 1'b0;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/synch_up_counter.sv
// Free-running synchronous binary up-counter built from toggle flip-flops
// with carry-lookahead toggle enables; all bits share one clock.
module synch_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] t;

    assign t[0] = 1'b1;

    // Each enable is a direct AND of all lower bits rather than a ripple chain.
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign t[i] = &Q[i-1:0];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff u_tff (
            .clk     (clk),
            .reset_n (reset_n),
            .t       (t[i]),
            .q       (Q[i])
        );
    end

endmodule

// File: tb/tb_synch_up_counter.sv
// Self-checking bench for synch_up_counter at WIDTH 4, 1 and 8 sharing one
// clock and reset; expected counts come from an edge-count model.
module tb_synch_up_counter;

    logic       clk;
    logic       reset_n;
    logic [3:0] q4;
    logic [0:0] q1;
    logic [7:0] q8;

    int nvec = 0;
    int nerr = 0;
    int cnt  = 0;   // edges since last reset release

    synch_up_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .Q(q4));
    synch_up_counter #(.WIDTH(1)) dut1 (.clk(clk), .reset_n(reset_n), .Q(q1));
    synch_up_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .Q(q8));

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int k;
        int q4;
        int q1;
        int q8;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the count is the number of edges since release, modulo 2^W.
    task automatic chk_model(input string tag);
        chk({tag, " w4"}, int'(q4), cnt % 16);
        chk({tag, " w1"}, int'(q1), cnt % 2);
        chk({tag, " w8"}, int'(q8), cnt % 256);
    endtask

    task automatic edge_step;
        @(posedge clk);
        if (reset_n) cnt++;
        #1;
    endtask

    initial begin
        tbl[0] = '{k: 1,   q4: 1,  q1: 1, q8: 1};
        tbl[1] = '{k: 2,   q4: 2,  q1: 0, q8: 2};
        tbl[2] = '{k: 14,  q4: 14, q1: 0, q8: 14};
        tbl[3] = '{k: 15,  q4: 15, q1: 1, q8: 15};
        tbl[4] = '{k: 16,  q4: 0,  q1: 0, q8: 16};
        tbl[5] = '{k: 17,  q4: 1,  q1: 1, q8: 17};
        tbl[6] = '{k: 20,  q4: 4,  q1: 0, q8: 20};
        tbl[7] = '{k: 256, q4: 0,  q1: 0, q8: 0};

        // Reset held across edges
        reset_n = 1'b0;
        #1;
        chk("rst_imm w4", int'(q4), 0);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("rst_hold w4", int'(q4), 0);
            chk("rst_hold w1", int'(q1), 0);
            chk("rst_hold w8", int'(q8), 0);
        end

        // Release between edges: no effect until the next edge
        #1 reset_n = 1'b1;
        cnt = 0;
        #1;
        chk("release w4", int'(q4), 0);
        chk("release w8", int'(q8), 0);

        // Table of edge counts after release, incl. WIDTH=4 and WIDTH=8 wraps
        begin
            int edges = 0;
            for (int v = 0; v < 8; v++) begin
                while (edges < tbl[v].k) begin
                    edge_step();
                    edges++;
                end
                chk($sformatf("tbl%0d w4", v), int'(q4), tbl[v].q4);
                chk($sformatf("tbl%0d w1", v), int'(q1), tbl[v].q1);
                chk($sformatf("tbl%0d w8", v), int'(q8), tbl[v].q8);
            end
        end

        // Async reset mid-count from Q=9 (WIDTH=4)
        while (int'(q4) != 9) edge_step();
        chk("pre_async w4", int'(q4), 9);
        #2 reset_n = 1'b0;
        #1;
        chk("async_clr w4", int'(q4), 0);
        chk("async_clr w8", int'(q8), 0);
        #2 reset_n = 1'b1;
        cnt = 0;
        edge_step();
        chk("after_async w4", int'(q4), 1);

        // Reset coincident with a rising edge while Q=7
        while (int'(q4) != 7) edge_step();
        chk("pre_edge w4", int'(q4), 7);
        @(negedge clk);
        #5 reset_n = 1'b0;
        #1;
        chk("edge_rst w4", int'(q4), 0);
        chk("edge_rst w1", int'(q1), 0);
        #3 reset_n = 1'b1;
        cnt = 0;
        edge_step();
        chk_model("after_edge_rst");

        // Randomized runs and reset pulses against the edge-count model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int off = $urandom_range(1, 4);
                int wid = $urandom_range(1, 3);
                #(off) reset_n = 1'b0;
                #1;
                cnt = 0;
                chk_model("rnd_rst");
                #(wid) reset_n = 1'b1;
            end else begin
                int n = $urandom_range(1, 40);
                for (int e = 0; e < n; e++) begin
                    edge_step();
                    chk_model("rnd_cnt");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
